// File: rtl/ps2_cmd_ctrl_pkg.sv
// ps2_cmd_ctrl_pkg: shared constants, error encoding and FSM state type for the PS/2 command sequencer.
// Revision: 1.0
`default_nettype none

package ps2_cmd_ctrl_pkg;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERROR     = 8'hFC;
  localparam logic [7:0] PS2_EN_REPORT = 8'hF4;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_DEVICE = 2'b01;
  localparam logic [1:0] ERR_RETRY  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    SEND     = 3'd2,
    WAIT_TX  = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer: loadable down-counter that saturates at zero; expired is high while the count is zero.
// Revision: 1.0
`default_nettype none

module ps2_timeout_timer #(
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMEOUT_CYC - 1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: PS/2 host command sequencer with ACK/RESEND/ERROR handling and bounded retry.
// Optional macro PS2_CMD_AUTO_INIT_EN issues 0xF4 after reset. Revision: 1.0
`default_nettype none

module ps2_cmd_ctrl
  import ps2_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] din,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       ack_tick,
  output logic       err_tick,
  output logic [1:0] err_code,
  output logic       busy
);

  state_t     state;
  logic [3:0] retry_cnt;
  logic       init_run;
  logic       timer_load;
  logic       timer_expired;
  logic       rx_hit;
  logic       retry_evt;

  // Strobe is gated by tx_idle in the same cycle so it can never reach a busy transmitter.
  assign wr_ps2     = (state == SEND) && tx_idle;
  assign timer_load = wr_ps2 || ((state == WAIT_TX) && tx_done_tick);
  assign rx_hit     = rx_done_tick &&
                      ((rx_dout == PS2_ACK) || (rx_dout == PS2_RESEND) || (rx_dout == PS2_ERROR));
  // A recognised response byte outranks a simultaneous timer expiry.
  assign retry_evt  = ((state == WAIT_TX) && !tx_done_tick && timer_expired) ||
                      ((state == WAIT_ACK) &&
                       ((rx_done_tick && (rx_dout == PS2_RESEND)) || (!rx_hit && timer_expired)));

  ps2_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef PS2_CMD_AUTO_INIT_EN
      state     <= INIT;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
`else
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
`endif
      retry_cnt <= 4'd0;
      init_run  <= 1'b0;
      din       <= 8'h00;
      ack_tick  <= 1'b0;
      err_tick  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      ack_tick <= 1'b0;
      err_tick <= 1'b0;
      err_code <= ERR_NONE;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            din       <= cmd_byte;
            retry_cnt <= 4'd0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        INIT: begin
          din       <= PS2_EN_REPORT;
          retry_cnt <= 4'd0;
          init_run  <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (tx_idle) state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (rx_done_tick && (rx_dout == PS2_ACK)) begin
            ack_tick <= !init_run;
            init_run <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (rx_done_tick && (rx_dout == PS2_ERROR)) begin
            err_tick <= 1'b1;
            err_code <= ERR_DEVICE;
            init_run <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (retry_evt) begin
        if (retry_cnt < 4'(MAX_RETRY)) begin
          retry_cnt <= retry_cnt + 4'd1;
          state     <= SEND;
        end else begin
          err_tick <= 1'b1;
          err_code <= ERR_RETRY;
          init_run <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_cmd_ctrl.sv
// tb_ps2_cmd_ctrl: directed self-checking bench for ps2_cmd_ctrl (TIMEOUT_CYC = 100, MAX_RETRY = 3).
// Revision: 1.0
`default_nettype none

module tb_ps2_cmd_ctrl;

  localparam int TCYC = 100;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] din;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       ack_tick;
  logic       err_tick;
  logic [1:0] err_code;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, ack_cnt = 0, err_cnt = 0, viol = 0;

  always #5 clk = ~clk;

  ps2_cmd_ctrl #(
    .TIMEOUT_CYC(TCYC),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .cmd_ready   (cmd_ready),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .rx_done_tick(rx_done_tick),
    .rx_dout     (rx_dout),
    .ack_tick    (ack_tick),
    .err_tick    (err_tick),
    .err_code    (err_code),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_ps2) begin
        wr_cnt++;
        if (!tx_idle) viol++;
      end
      if (ack_tick) ack_cnt++;
      if (err_tick) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else tick();
    end
    cmd_valid = 1'b1;
    cmd_byte  = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (wr_ps2) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic tx_done_after(input int n);
    repeat (n) tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic respond(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_dout      = b;
    tick();
    rx_done_tick = 1'b0;
    rx_dout      = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
`ifdef PS2_CMD_AUTO_INIT_EN
    begin
      bit ok;
      total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL init_rst: ready=%0b busy=%0b want 0/1", cmd_ready, busy); end
      reset = 1'b0;
      wait_wr(ok);
      total++; if (!ok || din !== 8'hF4) begin bad++; $display("FAIL init_din: seen=%0b din=%0h want F4", ok, din); end
      tick();
      tx_done_after(1);
      respond(8'hFA);
      total++; if (ack_tick !== 1'b0 || err_tick !== 1'b0) begin bad++; $display("FAIL init_noack: ack=%0b err=%0b want 0/0", ack_tick, err_tick); end
      tick();
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL init_ready: ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
    end
`else
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (wr_ps2 !== 1'b0) begin bad++; $display("FAIL rst_wr: got %0b want 0", wr_ps2); end
    total++; if (ack_tick !== 1'b0 || err_tick !== 1'b0) begin bad++; $display("FAIL rst_ticks: ack=%0b err=%0b want 0/0", ack_tick, err_tick); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL rst_code: got %0b want 00", err_code); end
    total++; if (din !== 8'h00) begin bad++; $display("FAIL rst_din: got %0h want 00", din); end
    reset = 1'b0;
    tick();
`endif
  endtask

  task automatic test_ack();
    int w0 = wr_cnt, a0 = ack_cnt, e0 = err_cnt;
    send_cmd(8'hF4);
    total++; if (wr_ps2 !== 1'b1 || din !== 8'hF4) begin bad++; $display("FAIL ack_strobe: wr=%0b din=%0h want 1/F4", wr_ps2, din); end
    tick();
    tx_done_after(59);
    repeat (5) tick();
    respond(8'hFA);
    total++; if (ack_tick !== 1'b1 || err_tick !== 1'b0) begin bad++; $display("FAIL ack_tick: ack=%0b err=%0b want 1/0", ack_tick, err_tick); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ack_ready_hold: got %0b want 0", cmd_ready); end
    tick();
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ack_ready_back: ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
    total++; if (wr_cnt - w0 != 1 || ack_cnt - a0 != 1 || err_cnt - e0 != 0) begin
      bad++; $display("FAIL ack_counts: wr=%0d ack=%0d err=%0d want 1/1/0", wr_cnt - w0, ack_cnt - a0, err_cnt - e0);
    end
  endtask

  task automatic test_resend();
    int w0 = wr_cnt, a0 = ack_cnt;
    bit ok;
    send_cmd(8'hED);
    for (int i = 0; i < 3; i++) begin
      wait_wr(ok);
      total++; if (!ok || din !== 8'hED) begin bad++; $display("FAIL resend_din%0d: seen=%0b din=%0h want ED", i, ok, din); end
      tick();
      tx_done_after(3);
      repeat (2) tick();
      respond((i < 2) ? 8'hFE : 8'hFA);
    end
    total++; if (ack_tick !== 1'b1) begin bad++; $display("FAIL resend_ack: got %0b want 1", ack_tick); end
    tick();
    total++; if (wr_cnt - w0 != 3 || ack_cnt - a0 != 1) begin bad++; $display("FAIL resend_counts: wr=%0d ack=%0d want 3/1", wr_cnt - w0, ack_cnt - a0); end
  endtask

  task automatic test_exhaust();
    int w0 = wr_cnt;
    bit ok;
    send_cmd(8'hF3);
    for (int i = 0; i < 4; i++) begin
      wait_wr(ok);
      total++; if (!ok) begin bad++; $display("FAIL exhaust_wr%0d: got none want strobe", i); end
      tick();
      tx_done_after(2);
      tick();
      respond(8'hFE);
    end
    total++; if (err_tick !== 1'b1 || err_code !== 2'b10) begin bad++; $display("FAIL exhaust_err: tick=%0b code=%0b want 1/10", err_tick, err_code); end
    total++; if (ack_tick !== 1'b0) begin bad++; $display("FAIL exhaust_noack: got %0b want 0", ack_tick); end
    repeat (5) tick();
    total++; if (wr_cnt - w0 != 4 || cmd_ready !== 1'b1) begin bad++; $display("FAIL exhaust_counts: wr=%0d ready=%0b want 4/1", wr_cnt - w0, cmd_ready); end
  endtask

  task automatic test_dev_error();
    int w0 = wr_cnt;
    send_cmd(8'hFF);
    tick();
    tx_done_after(2);
    respond(8'hFC);
    total++; if (err_tick !== 1'b1 || err_code !== 2'b01) begin bad++; $display("FAIL deverr_tick: tick=%0b code=%0b want 1/01", err_tick, err_code); end
    repeat (3) tick();
    total++; if (wr_cnt - w0 != 1 || busy !== 1'b0) begin bad++; $display("FAIL deverr_noretry: wr=%0d busy=%0b want 1/0", wr_cnt - w0, busy); end
  endtask

  task automatic test_timeout();
    send_cmd(8'hF2);
    tick();
    tx_done_after(2);
    repeat (TCYC - 1) tick();
    total++; if (wr_ps2 !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL timeout_early: wr=%0b busy=%0b want 0/1", wr_ps2, busy); end
    tick();
    total++; if (wr_ps2 !== 1'b1 || din !== 8'hF2) begin bad++; $display("FAIL timeout_retry: wr=%0b din=%0h want 1/F2", wr_ps2, din); end
    tick();
    tx_done_after(1);
    respond(8'hFA);
    total++; if (ack_tick !== 1'b1) begin bad++; $display("FAIL timeout_ack: got %0b want 1", ack_tick); end
    tick();
  endtask

  task automatic test_tx_idle_coincident();
    int w0 = wr_cnt;
    tx_idle = 1'b0;
    send_cmd(8'hEE);
    repeat (50) tick();
    total++; if (wr_cnt - w0 != 0) begin bad++; $display("FAIL idle_low_hold: wr=%0d want 0", wr_cnt - w0); end
    tx_idle = 1'b1;
    #1;
    total++; if (wr_ps2 !== 1'b1) begin bad++; $display("FAIL idle_rise_wr: got %0b want 1", wr_ps2); end
    tick();
    tx_done_after(1);
    repeat (TCYC - 1) tick();
    respond(8'hFA);
    total++; if (ack_tick !== 1'b1 || err_tick !== 1'b0) begin bad++; $display("FAIL coinc_ack: ack=%0b err=%0b want 1/0", ack_tick, err_tick); end
    repeat (3) tick();
    total++; if (wr_cnt - w0 != 1) begin bad++; $display("FAIL coinc_noretry: wr=%0d want 1", wr_cnt - w0); end
    total++; if (viol != 0) begin bad++; $display("FAIL strobe_gating: violations=%0d want 0", viol); end
  endtask

  task automatic test_reset_mid();
    int a0 = ack_cnt, e0 = err_cnt;
    send_cmd(8'hF5);
    tick();
    tx_done_after(1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_state: ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
    total++; if (ack_tick !== 1'b0 || err_tick !== 1'b0) begin bad++; $display("FAIL rst_mid_ticks: ack=%0b err=%0b want 0/0", ack_tick, err_tick); end
    reset = 1'b0;
    respond(8'hFA);
    tick();
    total++; if (ack_cnt - a0 != 0 || err_cnt - e0 != 0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_quiet: ack=%0d err=%0d ready=%0b want 0/0/1", ack_cnt - a0, err_cnt - e0, cmd_ready);
    end
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_byte     = 8'h00;
    tx_idle      = 1'b1;
    tx_done_tick = 1'b0;
    rx_done_tick = 1'b0;
    rx_dout      = 8'h00;
    test_reset();
    test_ack();
    test_resend();
    test_exhaust();
    test_dev_error();
    test_timeout();
    test_tx_idle_coincident();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
